// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives a JK flip-flop bank toward a target word,
// verifying by readback and retrying a bounded number of times.
module jk_excitation_driver #(
  parameter int WIDTH      = 8,
  parameter int MAX_RETRY  = 3,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_target,
  input  logic [WIDTH-1:0] i_q_fb,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [3:0]       o_retries
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_RETRY);

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] w_tgt_n;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_n;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] w_j_n;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] w_k_n;
  logic             r_done;
  logic             w_done_n;
  logic             r_err;
  logic             w_err_n;
  logic [3:0]       r_retries;
  logic [3:0]       w_retries_n;

  // Per-bit excitation moving q toward t; matching bits are held (J=K=0).
  function automatic logic [2*WIDTH-1:0] excite(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] t
  );
    logic [WIDTH-1:0] set_b;
    logic [WIDTH-1:0] clr_b;
    set_b = ~q & t;
    clr_b = q & ~t;
    if (USE_TOGGLE) excite = {set_b | clr_b, set_b | clr_b};
    else            excite = {set_b, clr_b};
  endfunction

  // State register and registered outputs; reset aborts any operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_tgt     <= '0;
      r_cnt     <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_retries <= '0;
    end else begin
      r_state   <= w_state_n;
      r_tgt     <= w_tgt_n;
      r_cnt     <= w_cnt_n;
      r_j       <= w_j_n;
      r_k       <= w_k_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
      r_retries <= w_retries_n;
    end
  end

  // Next-state: accept, drive one cycle, check readback, retry or finish.
  always_comb begin
    w_state_n   = r_state;
    w_tgt_n     = r_tgt;
    w_cnt_n     = r_cnt;
    w_j_n       = '0;
    w_k_n       = '0;
    w_done_n    = 1'b0;
    w_err_n     = 1'b0;
    w_retries_n = r_retries;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_tgt_n        = i_target;
          w_cnt_n        = '0;
          {w_j_n, w_k_n} = excite(i_q_fb, i_target);
          w_state_n      = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_state_n = S_CHECK;
      end
      S_CHECK: begin
        if (i_q_fb == r_tgt) begin
          w_done_n    = 1'b1;
          w_retries_n = r_cnt;
          w_state_n   = S_IDLE;
        end else if (r_cnt < LP_MAX) begin
          w_cnt_n        = r_cnt + 4'd1;
          {w_j_n, w_k_n} = excite(i_q_fb, r_tgt);
          w_state_n      = S_DRIVE;
        end else begin
          w_err_n     = 1'b1;
          w_retries_n = r_cnt;
          w_state_n   = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign o_j       = r_j;
  assign o_k       = r_k;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_retries = r_retries;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: set/reset and toggle instances side by side,
// each driving its own behavioural JK bank with optional faults.
module tb_jk_excitation_driver;

  localparam int W  = 8;
  localparam int MR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] target = '0;

  logic         bk_load = 1'b0;
  logic [W-1:0] bk_init = '0;
  logic [W-1:0] bk_stuck = '0;
  logic         bk_ign = 1'b0;

  logic [W-1:0] q0 = '0;
  logic [W-1:0] q1 = '0;
  logic         ign0 = 1'b0;
  logic         ign1 = 1'b0;

  logic [W-1:0] j0, k0, j1, k1;
  logic         busy0, busy1, done0, done1, err0, err1;
  logic [3:0]   ret0, ret1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(1'b0)) u_sr (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_target(target),
    .i_q_fb(q0), .o_j(j0), .o_k(k0), .o_busy(busy0),
    .o_done(done0), .o_err(err0), .o_retries(ret0)
  );

  jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(1'b1)) u_tg (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_target(target),
    .i_q_fb(q1), .o_j(j1), .o_k(k1), .o_busy(busy1),
    .o_done(done1), .o_err(err1), .o_retries(ret1)
  );

  // JK bank models: stuck-at-0 bits and an optional ignored first drive.
  always @(posedge clk) begin
    if (bk_load) begin
      q0 <= bk_init & ~bk_stuck;
      ign0 <= bk_ign;
    end else if (ign0 && ((j0 | k0) != '0)) begin
      ign0 <= 1'b0;
    end else begin
      q0 <= ((j0 & ~q0) | (~k0 & q0)) & ~bk_stuck;
    end
  end

  always @(posedge clk) begin
    if (bk_load) begin
      q1 <= bk_init & ~bk_stuck;
      ign1 <= bk_ign;
    end else if (ign1 && ((j1 | k1) != '0)) begin
      ign1 <= 1'b0;
    end else begin
      q1 <= ((j1 & ~q1) | (~k1 & q1)) & ~bk_stuck;
    end
  end

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_j0"}, j0, 8'h00);
    chk({tag, "_k0"}, k0, 8'h00);
    chk({tag, "_j1"}, j1, 8'h00);
    chk({tag, "_k1"}, k1, 8'h00);
    chk({tag, "_busy"}, {6'd0, busy1, busy0}, 8'h00);
    chk({tag, "_done"}, {6'd0, done1, done0}, 8'h00);
    chk({tag, "_err"}, {6'd0, err1, err0}, 8'h00);
    chk({tag, "_ret"}, {ret1, ret0}, 8'h00);
  endtask

  // One operation on both instances; expectations from the bank's intent:
  // an effective drive leaves the readback at target with stuck bits low.
  task automatic run_op(input string tag, input logic [W-1:0] t,
                        input logic [W-1:0] qi, input logic [W-1:0] s,
                        input bit ig);
    logic [W-1:0] qm, sj, sk;
    int d;
    bit ok;
    @(negedge clk);
    bk_load = 1'b1; bk_init = qi; bk_stuck = s; bk_ign = ig;
    @(negedge clk);
    bk_load = 1'b0; start = 1'b1; target = t;
    qm = qi & ~s;
    ok = 1'b0;
    for (d = 0; d <= MR; d++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      target = W'($urandom);
      sj = t & ~qm;
      sk = qm & ~t;
      chk({tag, "_drv_j0"}, j0, sj);
      chk({tag, "_drv_k0"}, k0, sk);
      chk({tag, "_drv_j1"}, j1, sj | sk);
      chk({tag, "_drv_k1"}, k1, sj | sk);
      chk({tag, "_drv_busy"}, {6'd0, busy1, busy0}, 8'h03);
      chk({tag, "_drv_fin"}, {4'd0, done1, err1, done0, err0}, 8'h00);
      if (!(ig && d == 0)) qm = t & ~s;
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      chk({tag, "_chk_jk"}, j0 | k0 | j1 | k1, 8'h00);
      chk({tag, "_chk_busy"}, {6'd0, busy1, busy0}, 8'h03);
      chk({tag, "_chk_fin"}, {4'd0, done1, err1, done0, err0}, 8'h00);
      if (qm == t) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_fin_done"}, {6'd0, done1, done0}, ok ? 8'h03 : 8'h00);
    chk({tag, "_fin_err"}, {6'd0, err1, err0}, ok ? 8'h00 : 8'h03);
    chk({tag, "_fin_busy"}, {6'd0, busy1, busy0}, 8'h00);
    chk({tag, "_fin_jk"}, j0 | k0 | j1 | k1, 8'h00);
    chk({tag, "_fin_ret0"}, {4'd0, ret0}, ok ? 8'(d) : 8'(MR));
    chk({tag, "_fin_ret1"}, {4'd0, ret1}, ok ? 8'(d) : 8'(MR));
  endtask

  initial begin
    logic [W-1:0] t, qi, s, qp;
    logic [W-1:0] tv [0:9];
    bit ig;

    repeat (2) @(negedge clk);
    chk_idle_zero("rst0");
    rst = 1'b0;

    run_op("setrst", 8'hF0, 8'h0F, 8'h00, 1'b0);
    run_op("same", 8'h3C, 8'h3C, 8'h00, 1'b0);
    run_op("stuck", 8'h01, 8'h00, 8'h01, 1'b0);
    run_op("recov", 8'hAA, 8'h00, 8'h00, 1'b1);
    run_op("stuck2", 8'h81, 8'h7E, 8'h80, 1'b1);

    // Reset during DRIVE aborts the operation silently.
    @(negedge clk);
    bk_load = 1'b1; bk_init = 8'h00; bk_stuck = 8'h00; bk_ign = 1'b0;
    @(negedge clk);
    bk_load = 1'b0; start = 1'b1; target = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy", {6'd0, busy1, busy0}, 8'h03);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("abort1");
    @(negedge clk);
    rst = 1'b0;
    chk_idle_zero("abort2");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort_quiet", {4'd0, done1, err1, done0, err0}, 8'h00);
    end

    for (int n = 0; n < 24; n++) begin
      t  = W'($urandom);
      qi = W'($urandom);
      s  = ($urandom_range(0, 2) == 0) ? W'($urandom) & W'($urandom) : '0;
      ig = ($urandom_range(0, 3) == 0) && ((qi & ~s) != t);
      run_op("rand", t, qi, s, ig);
    end

    // start held high with target changing every cycle.
    @(negedge clk);
    bk_load = 1'b1; bk_init = 8'h00; bk_stuck = 8'h00; bk_ign = 1'b0;
    for (int c = 0; c < 10; c++) tv[c] = W'($urandom);
    qp = '0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      bk_load = 1'b0;
      if (c > 0) begin
        if (c % 3 == 1) begin
          chk("b2b_j0", j0, tv[c-1] & ~qp);
          chk("b2b_k0", k0, qp & ~tv[c-1]);
          chk("b2b_j1", j1, tv[c-1] ^ qp);
          qp = tv[c-1];
        end else begin
          chk("b2b_jk", j0 | k0 | j1 | k1, 8'h00);
        end
        chk("b2b_busy", {6'd0, busy1, busy0}, (c % 3 == 0) ? 8'h00 : 8'h03);
        chk("b2b_done", {6'd0, done1, done0}, (c % 3 == 0) ? 8'h03 : 8'h00);
        chk("b2b_err", {6'd0, err1, err0}, 8'h00);
      end
      start = (c < 9);
      target = tv[c];
    end
    @(negedge clk);
    chk("b2b_tail", {4'd0, busy1, busy0, done1, done0}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
